// File: rtl/as608_pkg.sv
// Shared constants and types for the AS608 packet receiver: frame header
// bytes, packet identifiers, error codes and the parser state encoding.
package as608_pkg;

   localparam logic [7:0] HDR_B0   = 8'hEF;
   localparam logic [7:0] HDR_B1   = 8'h01;

   localparam logic [7:0] PID_CMD  = 8'h01;
   localparam logic [7:0] PID_DATA = 8'h02;
   localparam logic [7:0] PID_ACK  = 8'h07;
   localparam logic [7:0] PID_END  = 8'h08;

   typedef enum logic [1:0] {
      ERR_HDR = 2'd0,
      ERR_CHK = 2'd1,
      ERR_TMO = 2'd2,
      ERR_LEN = 2'd3
   } err_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HDR1,
      ST_ADDR,
      ST_PID,
      ST_LEN_H,
      ST_LEN_L,
      ST_PAYLOAD,
      ST_CHK_H,
      ST_CHK_L
   } state_t;

   function automatic logic pid_known(input logic [7:0] pid);
      return (pid == PID_CMD) || (pid == PID_DATA) || (pid == PID_ACK) || (pid == PID_END);
   endfunction

endpackage

// File: rtl/as608_pkt_rx_if.sv
// Byte stream in from the UART receiver and word write port out to the
// fingerprint store RAM.
interface as608_pkt_rx_if;
   logic         rx_valid;
   logic [7:0]   rx_data;
   logic         ram_we;
   logic [7:0]   ram_add;
   logic [255:0] ram_data;
   logic         ram_sel;

   modport master (output rx_valid, rx_data, input ram_we, ram_add, ram_data, ram_sel);
   modport slave  (input rx_valid, rx_data, output ram_we, ram_add, ram_data, ram_sel);
endinterface

// File: rtl/as608_byte_packer.sv
// Packs payload bytes into 256-bit RAM words, first byte in the top lane.
// Writes a word every 32 bytes or on flush (zero padded), counts words,
// and drops writes past word 255 while raising a sticky overflow flag.
module as608_byte_packer (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         byte_valid,
   input  logic [7:0]   byte_data,
   input  logic         flush,
   input  logic         discard,
   output logic         we,
   output logic [7:0]   add,
   output logic [255:0] data,
   output logic         ovf
);
   logic [4:0]   cnt_q, cnt_b;
   logic [255:0] word_q, word_b, word_n;
   logic [8:0]   wcnt_q, wcnt_b;
   logic         do_wr;

   // clear takes effect first so a coincident byte lands as byte 0
   always_comb begin
      cnt_b  = clear ? 5'd0 : cnt_q;
      word_b = clear ? '0 : word_q;
      wcnt_b = clear ? 9'd0 : wcnt_q;
      word_n = word_b;
      if (byte_valid) word_n[{~cnt_b, 3'b111} -: 8] = byte_data;
      do_wr  = byte_valid && ((cnt_b == 5'd31) || flush);
   end

   // word buffer, write strobe, word address and overflow tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         word_q <= '0;
         wcnt_q <= '0;
         we     <= 1'b0;
         add    <= '0;
         data   <= '0;
         ovf    <= 1'b0;
      end else begin
         we     <= 1'b0;
         wcnt_q <= wcnt_b;
         if (clear) begin
            add <= '0;
            ovf <= 1'b0;
         end
         if (discard) begin
            cnt_q  <= '0;
            word_q <= '0;
         end else if (do_wr) begin
            cnt_q  <= '0;
            word_q <= '0;
            if (!wcnt_b[8]) begin
               we     <= 1'b1;
               add    <= wcnt_b[7:0];
               data   <= word_n;
               wcnt_q <= wcnt_b + 9'd1;
            end else begin
               ovf <= 1'b1;
            end
         end else begin
            cnt_q  <= byte_valid ? cnt_b + 5'd1 : cnt_b;
            word_q <= word_n;
         end
      end
   end
endmodule

// File: rtl/as608_pkt_rx.sv
// AS608 frame parser and capture stage. Optional build macro:
// AS608_TIMEOUT_EN adds an inter-byte gap timeout that aborts a frame.
//
// state      | meaning
// -----------+--------------------------------------------
// ST_IDLE    | hunting for 0xEF
// ST_HDR1    | expecting 0x01 (0xEF re-syncs here)
// ST_ADDR    | four module address bytes, MSB first
// ST_PID     | packet identifier
// ST_LEN_H   | length high byte
// ST_LEN_L   | length low byte, range check
// ST_PAYLOAD | payload bytes (length - 2)
// ST_CHK_H   | checksum high byte
// ST_CHK_L   | checksum low byte, report result
module as608_pkt_rx
   import as608_pkg::*;
#(
   parameter logic [31:0] DEV_ADDR    = 32'hFFFF_FFFF,
   parameter int          MAX_LEN     = 256,
   parameter int          TIMEOUT_CYC = 90000
) (
   input  logic             clk,
   input  logic             rst,
   as608_pkt_rx_if.slave    bus,
   input  logic             cap_start,
   input  logic             cap_sel,
   output logic             ack_valid,
   output logic [7:0]       ack_code,
   output logic             cap_done,
   output logic             pkt_err,
   output logic [1:0]       err_code,
   output logic             busy,
   output logic             ovf
);
   localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

   state_t      state_q, state_n;
   logic [1:0]  addr_idx_q;
   logic [7:0]  pid_q, len_h_q, chk_h_q;
   logic [15:0] pay_len_q, pay_cnt_q, csum_q;
   logic        armed_q;
   logic [15:0] len_w;
   logic        armed_eff, is_data, pay_last;
   logic        err_set, ack_set, done_set, pack_en, flush_en, tmo_discard;
   err_t        err_val;

   assign len_w     = {len_h_q, bus.rx_data};
   assign armed_eff = cap_start | armed_q;
   assign is_data   = (pid_q == PID_DATA) || (pid_q == PID_END);
   assign pay_last  = (pay_cnt_q == pay_len_q - 16'd1);
   assign busy      = (state_q != ST_IDLE);

`ifdef AS608_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_q;
   logic             tmo_hit;

   assign tmo_hit     = !bus.rx_valid && (state_q != ST_IDLE) && (tmo_q == '0);
   assign tmo_discard = tmo_hit;

   // gap down-counter, reloaded by every byte and while idle
   always_ff @(posedge clk) begin
      if (rst || bus.rx_valid || state_q == ST_IDLE) tmo_q <= TMO_W'(TIMEOUT_CYC - 1);
      else if (tmo_q != '0)                          tmo_q <= tmo_q - 1'b1;
   end
`else
   assign tmo_discard = 1'b0;
`endif

   // parser state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_n;
   end

   // next state and per-byte event decode
   always_comb begin
      state_n  = state_q;
      err_set  = 1'b0;
      err_val  = ERR_HDR;
      ack_set  = 1'b0;
      done_set = 1'b0;
      pack_en  = 1'b0;
      flush_en = 1'b0;
      if (bus.rx_valid) begin
         case (state_q)
            ST_IDLE:  if (bus.rx_data == HDR_B0) state_n = ST_HDR1;
            ST_HDR1: begin
               if (bus.rx_data == HDR_B1)      state_n = ST_ADDR;
               else if (bus.rx_data != HDR_B0) state_n = ST_IDLE;
            end
            ST_ADDR: begin
               if (bus.rx_data != DEV_ADDR[{~addr_idx_q, 3'b000} +: 8]) begin
                  state_n = ST_IDLE;
                  err_set = 1'b1;
               end else if (addr_idx_q == 2'd3) begin
                  state_n = ST_PID;
               end
            end
            ST_PID: begin
               if (pid_known(bus.rx_data)) state_n = ST_LEN_H;
               else begin
                  state_n = ST_IDLE;
                  err_set = 1'b1;
               end
            end
            ST_LEN_H: state_n = ST_LEN_L;
            ST_LEN_L: begin
               if (len_w < 16'd2 || (len_w - 16'd2) > MAX_LEN16) begin
                  state_n = ST_IDLE;
                  err_set = 1'b1;
                  err_val = ERR_LEN;
               end else if (len_w == 16'd2) begin
                  state_n = ST_CHK_H;
               end else begin
                  state_n = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               pack_en  = is_data && armed_eff;
               flush_en = pay_last && (pid_q == PID_END);
               if (pay_last) state_n = ST_CHK_H;
            end
            ST_CHK_H: state_n = ST_CHK_L;
            ST_CHK_L: begin
               state_n = ST_IDLE;
               if ({chk_h_q, bus.rx_data} != csum_q) begin
                  err_set = 1'b1;
                  err_val = ERR_CHK;
               end else if (pid_q == PID_ACK) begin
                  ack_set = 1'b1;
               end
               if (pid_q == PID_END) done_set = 1'b1;
            end
            default: state_n = ST_IDLE;
         endcase
      end
`ifdef AS608_TIMEOUT_EN
      else if (tmo_hit) begin
         state_n = ST_IDLE;
         err_set = 1'b1;
         err_val = ERR_TMO;
      end
`endif
   end

   // frame fields, running checksum, output pulses and capture arming
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_idx_q  <= '0;
         pid_q       <= '0;
         len_h_q     <= '0;
         chk_h_q     <= '0;
         pay_len_q   <= '0;
         pay_cnt_q   <= '0;
         csum_q      <= '0;
         armed_q     <= 1'b0;
         ack_valid   <= 1'b0;
         ack_code    <= '0;
         cap_done    <= 1'b0;
         pkt_err     <= 1'b0;
         err_code    <= '0;
         bus.ram_sel <= 1'b0;
      end else begin
         ack_valid <= ack_set;
         cap_done  <= done_set;
         pkt_err   <= err_set;
         if (err_set) err_code <= err_val;
         if (cap_start) begin
            armed_q     <= 1'b1;
            bus.ram_sel <= cap_sel;
         end
         if (done_set) armed_q <= 1'b0;
         if (bus.rx_valid) begin
            case (state_q)
               ST_HDR1:  addr_idx_q <= '0;
               ST_ADDR:  addr_idx_q <= addr_idx_q + 2'd1;
               ST_PID: begin
                  pid_q  <= bus.rx_data;
                  csum_q <= {8'h00, bus.rx_data};
               end
               ST_LEN_H: begin
                  len_h_q <= bus.rx_data;
                  csum_q  <= csum_q + {8'h00, bus.rx_data};
               end
               ST_LEN_L: begin
                  pay_len_q <= len_w - 16'd2;
                  pay_cnt_q <= '0;
                  csum_q    <= csum_q + {8'h00, bus.rx_data};
                  if (pid_q == PID_ACK && len_w == 16'd2) ack_code <= 8'h00;
               end
               ST_PAYLOAD: begin
                  pay_cnt_q <= pay_cnt_q + 16'd1;
                  csum_q    <= csum_q + {8'h00, bus.rx_data};
                  if (pid_q == PID_ACK && pay_cnt_q == 16'd0) ack_code <= bus.rx_data;
               end
               ST_CHK_H: chk_h_q <= bus.rx_data;
               default: ;
            endcase
         end
      end
   end

   as608_byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (cap_start),
      .byte_valid (pack_en),
      .byte_data  (bus.rx_data),
      .flush      (flush_en),
      .discard    (tmo_discard),
      .we         (bus.ram_we),
      .add        (bus.ram_add),
      .data       (bus.ram_data),
      .ovf        (ovf)
   );
endmodule

// File: tb/tb_as608_pkt_rx.sv
// Self-checking bench for as608_pkt_rx: frames are built from byte lists,
// expected acks/errors/RAM words come from a byte-queue capture model.
`timescale 1ns/1ps
module tb_as608_pkt_rx;
   localparam int MAXL = 256;
   localparam int TMO  = 400;

   logic       clk = 1'b0, rst = 1'b1, cap_start = 1'b0, cap_sel = 1'b0;
   logic       ack_valid, cap_done, pkt_err, busy, ovf;
   logic [7:0] ack_code;
   logic [1:0] err_code;
   int         checks = 0, failures = 0;
   int         cyc = 0, last_cyc = 0, ack_cyc = 0, done_cyc = 0, err_cyc = 0, last_wr_cyc = 0;

   as608_pkt_rx_if bus ();

   as608_pkt_rx #(.DEV_ADDR(32'hFFFF_FFFF), .MAX_LEN(MAXL), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .bus(bus), .cap_start(cap_start), .cap_sel(cap_sel),
      .ack_valid(ack_valid), .ack_code(ack_code), .cap_done(cap_done), .pkt_err(pkt_err),
      .err_code(err_code), .busy(busy), .ovf(ovf));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed { logic [7:0] add; logic [255:0] data; } wr_t;
   wr_t        wr_q[$], exp_wr[$];
   logic [7:0] ack_q[$];
   logic [1:0] err_q[$];
   int         done_n;
   logic [7:0] pkt[$], pay[$];
   logic [7:0] m_buf[$];
   int         m_words;
   bit         m_armed, m_ovf;

   // event monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.ram_we) begin wr_q.push_back({bus.ram_add, bus.ram_data}); last_wr_cyc = cyc; end
      if (ack_valid) begin ack_q.push_back(ack_code); ack_cyc = cyc; end
      if (pkt_err) begin err_q.push_back(err_code); err_cyc = cyc; end
      if (cap_done) begin done_n++; done_cyc = cyc; end
   end

   function automatic void build(input logic [7:0] pid, input logic [15:0] len, input bit bad);
      logic [15:0] s;
      s = 16'(pid) + 16'(len[15:8]) + 16'(len[7:0]);
      foreach (pay[i]) s = s + 16'(pay[i]);
      if (bad) s = s + 16'd1;
      pkt = {8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, pid, len[15:8], len[7:0]};
      foreach (pay[i]) pkt.push_back(pay[i]);
      pkt.push_back(s[15:8]);
      pkt.push_back(s[7:0]);
   endfunction

   function automatic void rand_pay(input int n);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
   endfunction

   function automatic void m_emit();
      logic [255:0] w;
      w = '0;
      while (m_buf.size() < 32) m_buf.push_back(8'h00);
      for (int i = 0; i < 32; i++) w[255 - 8*i -: 8] = m_buf[i];
      m_buf.delete();
      if (m_words < 256) begin
         exp_wr.push_back({8'(m_words), w});
         m_words++;
      end else m_ovf = 1'b1;
   endfunction

   function automatic void m_feed(input logic [7:0] pid);
      if (m_armed && (pid == 8'h02 || pid == 8'h08)) begin
         foreach (pay[i]) begin
            m_buf.push_back(pay[i]);
            if (m_buf.size() == 32) m_emit();
         end
         if (pid == 8'h08 && m_buf.size() > 0) m_emit();
      end
      if (pid == 8'h08) m_armed = 1'b0;
   endfunction

   task automatic clear_mon();
      wr_q.delete(); exp_wr.delete(); ack_q.delete(); err_q.delete(); done_n = 0;
   endtask

   task automatic settle();
      repeat (4) @(negedge clk);
   endtask

   task automatic send(input int lo, input int hi, input int gap_max);
      for (int i = lo; i <= hi; i++) begin
         @(negedge clk);
         bus.rx_valid = 1'b1; bus.rx_data = pkt[i]; last_cyc = cyc;
         if (gap_max > 0) begin
            int g;
            g = $urandom_range(gap_max, 0);
            if (g > 0) begin
               @(negedge clk); bus.rx_valid = 1'b0;
               repeat (g - 1) @(negedge clk);
            end
         end
      end
      @(negedge clk); bus.rx_valid = 1'b0;
   endtask

   task automatic cap(input logic sel);
      @(negedge clk); cap_start = 1'b1; cap_sel = sel;
      @(negedge clk); cap_start = 1'b0;
      m_buf.delete(); m_words = 0; m_ovf = 1'b0; m_armed = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if ({bus.ram_we, bus.ram_add, bus.ram_sel} !== 10'd0) begin failures++; $display("FAIL reset_ram got=%0h exp=0", {bus.ram_we, bus.ram_add, bus.ram_sel}); end
      checks++; if (bus.ram_data !== 256'd0) begin failures++; $display("FAIL reset_ram_data got=%0h exp=0", bus.ram_data); end
      checks++; if ({ack_valid, ack_code, cap_done, pkt_err, err_code} !== 13'd0) begin failures++; $display("FAIL reset_flags got=%0h exp=0", {ack_valid, ack_code, cap_done, pkt_err, err_code}); end
      checks++; if ({busy, ovf} !== 2'b00) begin failures++; $display("FAIL reset_busy_ovf got=%b exp=00", {busy, ovf}); end
      rst = 1'b0;
      settle();
   endtask

   task automatic test_ack_basic();
      clear_mon();
      pkt = {8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h03, 8'h00, 8'h00, 8'h0A};
      send(0, 11, 0); settle();
      checks++; if (ack_q.size() !== 1) begin failures++; $display("FAIL ack_basic_count got=%0d exp=1", ack_q.size()); end
      else begin
         checks++; if (ack_q[0] !== 8'h00) begin failures++; $display("FAIL ack_basic_code got=%0h exp=0", ack_q[0]); end
         checks++; if (ack_cyc !== last_cyc + 1) begin failures++; $display("FAIL ack_latency got=%0d exp=%0d", ack_cyc, last_cyc + 1); end
      end
      checks++; if (err_q.size() !== 0) begin failures++; $display("FAIL ack_basic_err got=%0d exp=0", err_q.size()); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ack_basic_busy got=%b exp=0", busy); end
   endtask

   task automatic test_chk_err();
      clear_mon();
      pkt = {8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h03, 8'h00, 8'h00, 8'h0B};
      send(0, 11, 0); settle();
      checks++; if (err_q.size() !== 1 || err_q[0] !== 2'd1) begin failures++; $display("FAIL chk_err_code got_n=%0d exp=1 code1", err_q.size()); end
      checks++; if (ack_q.size() !== 0) begin failures++; $display("FAIL chk_err_ack got=%0d exp=0", ack_q.size()); end
      clear_mon();
      pay = {8'h5A}; build(8'h07, 16'd3, 1'b0);
      send(0, pkt.size() - 1, 1); settle();
      checks++; if (ack_q.size() !== 1 || ack_q[0] !== 8'h5A) begin failures++; $display("FAIL chk_err_recover got_n=%0d exp=1 code 5a", ack_q.size()); end
      checks++; if (err_code !== 2'd1) begin failures++; $display("FAIL err_code_hold got=%0d exp=1", err_code); end
   endtask

   task automatic test_ack_random();
      for (int k = 0; k < 8; k++) begin
         int n; bit bad; logic [7:0] code;
         n = $urandom_range(0, 6);
         bad = ($urandom_range(0, 3) == 0);
         rand_pay(n);
         code = (n > 0) ? pay[0] : 8'h00;
         clear_mon();
         build(8'h07, 16'(n + 2), bad);
         send(0, pkt.size() - 1, 2); settle();
         checks++; if (ack_q.size() !== (bad ? 0 : 1)) begin failures++; $display("FAIL ack_rand_count got=%0d exp=%0d", ack_q.size(), bad ? 0 : 1); end
         checks++; if (ack_code !== code) begin failures++; $display("FAIL ack_rand_code got=%0h exp=%0h", ack_code, code); end
         checks++; if (err_q.size() !== (bad ? 1 : 0)) begin failures++; $display("FAIL ack_rand_err got=%0d exp=%0d", err_q.size(), bad ? 1 : 0); end
      end
   endtask

   task automatic test_capture();
      clear_mon();
      cap(1'b1);
      pay.delete(); for (int i = 0; i < 64; i++) pay.push_back(8'(i));
      build(8'h02, 16'd66, 1'b0); m_feed(8'h02); send(0, pkt.size() - 1, 0);
      pay.delete(); for (int i = 0; i < 8; i++) pay.push_back(8'(8'hA0 + i));
      build(8'h08, 16'd10, 1'b0); m_feed(8'h08); send(0, pkt.size() - 1, 0);
      settle();
      checks++; if (wr_q.size() !== 3) begin failures++; $display("FAIL cap_count got=%0d exp=3", wr_q.size()); end
      for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
         checks++; if (wr_q[i] !== exp_wr[i]) begin failures++; $display("FAIL cap_word%0d got=%0h exp=%0h", i, wr_q[i], exp_wr[i]); end
      end
      checks++; if (done_n !== 1) begin failures++; $display("FAIL cap_done_count got=%0d exp=1", done_n); end
      checks++; if (done_cyc - last_wr_cyc < 2) begin failures++; $display("FAIL flush_lead got=%0d exp>=2", done_cyc - last_wr_cyc); end
      checks++; if ({bus.ram_sel, bus.ram_add} !== {1'b1, 8'd2}) begin failures++; $display("FAIL cap_sel_add got=%b/%0d exp=1/2", bus.ram_sel, bus.ram_add); end
      checks++; if (err_q.size() !== 0) begin failures++; $display("FAIL cap_err got=%0d exp=0", err_q.size()); end
      clear_mon();
      rand_pay(40); build(8'h02, 16'd42, 1'b0); send(0, pkt.size() - 1, 0); settle();
      checks++; if (wr_q.size() !== 0) begin failures++; $display("FAIL disarmed_write got=%0d exp=0", wr_q.size()); end
   endtask

   task automatic test_addr_err();
      clear_mon();
      pkt = {8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFE, 8'hFF, 8'h07, 8'h00, 8'h03, 8'h00, 8'h00, 8'h0A};
      send(0, 11, 0); settle();
      checks++; if (err_q.size() !== 1 || err_q[0] !== 2'd0) begin failures++; $display("FAIL addr_err got_n=%0d exp=1 code0", err_q.size()); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL addr_err_busy got=%b exp=0", busy); end
      pkt[4] = 8'hFF;
      send(0, 11, 0); settle();
      checks++; if (ack_q.size() !== 1) begin failures++; $display("FAIL addr_err_recover got=%0d exp=1", ack_q.size()); end
   endtask

   task automatic test_hdr_len_err();
      clear_mon();
      pkt = {8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h05};
      send(0, 6, 0); settle();
      checks++; if (err_q.size() !== 1 || err_q[0] !== 2'd0) begin failures++; $display("FAIL pid_err got_n=%0d exp=1 code0", err_q.size()); end
      clear_mon();
      pkt = {8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h01, 8'h03};
      send(0, 8, 0); settle();
      checks++; if (err_q.size() !== 1 || err_q[0] !== 2'd3) begin failures++; $display("FAIL len_max_err got_n=%0d exp=1 code3", err_q.size()); end
      clear_mon();
      pkt = {8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h01};
      send(0, 8, 0); settle();
      checks++; if (err_q.size() !== 1 || err_q[0] !== 2'd3) begin failures++; $display("FAIL len_min_err got_n=%0d exp=1 code3", err_q.size()); end
      clear_mon();
      pkt = {8'hEF, 8'h02};
      send(0, 1, 0); settle();
      checks++; if (err_q.size() !== 0 || busy !== 1'b0) begin failures++; $display("FAIL hdr1_silent got_n=%0d busy=%b exp=0/0", err_q.size(), busy); end
      pkt = {8'hEF, 8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h03, 8'h00, 8'h00, 8'h0A};
      send(0, 12, 0); settle();
      checks++; if (ack_q.size() !== 1) begin failures++; $display("FAIL hdr1_resync got=%0d exp=1", ack_q.size()); end
   endtask

   task automatic test_random_capture();
      for (int r = 0; r < 3; r++) begin
         logic sel; int np, nbad;
         clear_mon();
         sel = 1'($urandom_range(0, 1));
         cap(sel);
         np = $urandom_range(1, 3); nbad = 0;
         for (int p = 0; p < np; p++) begin
            int n; bit bad;
            n = $urandom_range(1, MAXL);
            bad = ($urandom_range(0, 3) == 0);
            if (bad) nbad++;
            rand_pay(n); build(8'h02, 16'(n + 2), bad); m_feed(8'h02);
            send(0, pkt.size() - 1, 2);
         end
         rand_pay($urandom_range(1, 70)); build(8'h08, 16'(pay.size() + 2), 1'b0); m_feed(8'h08);
         send(0, pkt.size() - 1, 2); settle();
         checks++; if (wr_q.size() !== exp_wr.size()) begin failures++; $display("FAIL rcap_count got=%0d exp=%0d", wr_q.size(), exp_wr.size()); end
         for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
            checks++; if (wr_q[i] !== exp_wr[i]) begin failures++; $display("FAIL rcap_word%0d got=%0h exp=%0h", i, wr_q[i], exp_wr[i]); end
         end
         checks++; if (done_n !== 1 || err_q.size() !== nbad) begin failures++; $display("FAIL rcap_done_err got=%0d/%0d exp=1/%0d", done_n, err_q.size(), nbad); end
         checks++; if (bus.ram_sel !== sel) begin failures++; $display("FAIL rcap_sel got=%b exp=%b", bus.ram_sel, sel); end
         if (exp_wr.size() > 0) begin
            checks++; if (bus.ram_add !== exp_wr[exp_wr.size() - 1].add) begin failures++; $display("FAIL rcap_add got=%0d exp=%0d", bus.ram_add, exp_wr[exp_wr.size() - 1].add); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] all[$]; logic [7:0] a, b;
      clear_mon();
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      pay = {a}; build(8'h07, 16'd3, 1'b0); all = pkt;
      rand_pay(3); build(8'h01, 16'd5, 1'b0); foreach (pkt[i]) all.push_back(pkt[i]);
      pay = {b, 8'h11}; build(8'h07, 16'd4, 1'b0); foreach (pkt[i]) all.push_back(pkt[i]);
      pkt = all;
      send(0, pkt.size() - 1, 0); settle();
      checks++; if (ack_q.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", ack_q.size()); end
      else begin
         checks++; if ({ack_q[0], ack_q[1]} !== {a, b}) begin failures++; $display("FAIL b2b_codes got=%0h exp=%0h", {ack_q[0], ack_q[1]}, {a, b}); end
      end
      checks++; if (err_q.size() !== 0 || wr_q.size() !== 0) begin failures++; $display("FAIL b2b_side got=%0d/%0d exp=0/0", err_q.size(), wr_q.size()); end
   endtask

   task automatic test_ovf();
      clear_mon();
      cap(1'b0);
      for (int p = 0; p < 33; p++) begin
         rand_pay(MAXL); build(8'h02, 16'(MAXL + 2), 1'b0); m_feed(8'h02);
         send(0, pkt.size() - 1, 0);
      end
      settle();
      checks++; if (wr_q.size() !== exp_wr.size()) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", wr_q.size(), exp_wr.size()); end
      for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
         checks++; if (wr_q[i] !== exp_wr[i]) begin failures++; $display("FAIL ovf_word%0d got=%0h exp=%0h", i, wr_q[i], exp_wr[i]); end
      end
      checks++; if (ovf !== m_ovf || bus.ram_add !== 8'd255) begin failures++; $display("FAIL ovf_flag got=%b/%0d exp=%b/255", ovf, bus.ram_add, m_ovf); end
      checks++; if (err_q.size() !== 0) begin failures++; $display("FAIL ovf_err got=%0d exp=0", err_q.size()); end
      cap(1'b0); settle();
      checks++; if (ovf !== 1'b0 || bus.ram_add !== 8'd0) begin failures++; $display("FAIL ovf_clear got=%b/%0d exp=0/0", ovf, bus.ram_add); end
   endtask

   task automatic test_timeout();
      clear_mon();
      pkt = {8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h03, 8'h00, 8'h00, 8'h0A};
      send(0, 7, 0);
`ifdef AS608_TIMEOUT_EN
      for (int i = 0; i < TMO + 20 && err_q.size() == 0; i++) @(negedge clk);
      settle();
      checks++; if (err_q.size() !== 1 || err_q[0] !== 2'd2) begin failures++; $display("FAIL timeout_err got_n=%0d exp=1 code2", err_q.size()); end
      else begin
         checks++; if (err_cyc !== last_cyc + TMO + 1) begin failures++; $display("FAIL timeout_cyc got=%0d exp=%0d", err_cyc, last_cyc + TMO + 1); end
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%b exp=0", busy); end
      send(0, 11, 0); settle();
      checks++; if (ack_q.size() !== 1) begin failures++; $display("FAIL timeout_recover got=%0d exp=1", ack_q.size()); end
`else
      repeat (200) @(negedge clk);
      checks++; if (busy !== 1'b1 || err_q.size() !== 0) begin failures++; $display("FAIL no_timeout got=%b/%0d exp=1/0", busy, err_q.size()); end
      send(8, 11, 0); settle();
      checks++; if (ack_q.size() !== 1 || ack_q[0] !== 8'h00) begin failures++; $display("FAIL no_timeout_ack got=%0d exp=1", ack_q.size()); end
`endif
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      test_reset();
      test_ack_basic();
      test_chk_err();
      test_ack_random();
      test_capture();
      test_addr_err();
      test_hdr_len_err();
      test_random_capture();
      test_back_to_back();
      test_ovf();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
